barrel_shifter_left_seq: RTL and testbench

//   Sequential left shifter. It is the left-direction companion to the 4-bit combinational right shifter.
//   It accepts an operand and a shift amount over a valid/ready handshake.
//   It shifts left by one bit per clock, using either zero-fill or rotate.
//   It holds the result until the consumer takes it.

---
 rtl/barrel_shifter_left_seq.sv | 83 ++++++++
 tb/tb_barrel_shifter_left_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_shifter_left_seq.sv
// ============================================================================
//  Module      : barrel_shifter_left_seq
//  Description : Bit-serial left shifter (zero-fill or rotate), one position
//                per clock, with valid/ready handshakes on input and output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module barrel_shifter_left_seq #(
   parameter int WIDTH = 4,
   parameter int SHW   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] d,
   input  logic [SHW-1:0]   s,
   input  logic             rot,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             busy
);

   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_shift = 2'd1;
   localparam logic [1:0] c_st_done  = 2'd2;

   localparam logic [SHW-1:0] c_one = SHW'(1);

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_y;
   logic [SHW-1:0]   r_count;
   logic             r_rot;
   logic [WIDTH-1:0] w_y_shifted;

   // Rotate feeds the MSB back into the LSB; logical mode shifts in a zero.
   assign w_y_shifted = {r_y[WIDTH-2:0], (r_rot & r_y[WIDTH-1])};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_st_idle;
         r_y     <= '0;
         r_count <= '0;
         r_rot   <= 1'b0;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (in_valid) begin
                  r_y     <= d;
                  r_count <= s;
                  r_rot   <= rot;
                  r_state <= (s != '0) ? c_st_shift : c_st_done;
               end
            end
            c_st_shift: begin
               r_y     <= w_y_shifted;
               r_count <= r_count - c_one;
               if (r_count == c_one) begin
                  r_state <= c_st_done;
               end
            end
            c_st_done: begin
               if (out_ready) begin
                  r_state <= c_st_idle;
               end
            end
            default: begin
               r_state <= c_st_idle;
            end
         endcase
      end
   end

   assign in_ready  = (r_state == c_st_idle);
   assign out_valid = (r_state == c_st_done);
   assign busy      = (r_state == c_st_shift) || (r_state == c_st_done);
   assign y         = r_y;

endmodule

`default_nettype wire

// File: tb/tb_barrel_shifter_left_seq.sv
// ============================================================================
//  Module      : tb_barrel_shifter_left_seq
//  Description : Directed self-checking bench for barrel_shifter_left_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_barrel_shifter_left_seq;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] d;
   logic [1:0] s;
   logic       rot;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] y;
   logic       busy;

   int n_checks;
   int n_fail;

   barrel_shifter_left_seq #(.WIDTH(4), .SHW(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .d         (d),
      .s         (s),
      .rot       (rot),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one operand, counts edges from the accept edge until out_valid.
   task automatic run_op(input logic [3:0] od, input logic [1:0] os, input logic orot,
                         output logic [3:0] res, output int lat);
      int guard;
      guard = 0;
      while (!in_ready && guard < 20) begin
         tick();
         guard++;
      end
      d        = od;
      s        = os;
      rot      = orot;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      d        = 4'b0000;
      s        = 2'd0;
      lat      = 1;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      res = y;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      d         = 4'b0000;
      s         = 2'd0;
      rot       = 1'b0;
      out_ready = 1'b1;
      repeat (2) tick();
      n_checks++;
      if (y !== 4'b0000 || in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: y=%b in_ready=%b out_valid=%b busy=%b, required y=0000 in_ready=1 out_valid=0 busy=0",
                  y, in_ready, out_valid, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_logical();
      logic [3:0] res;
      int lat;
      logic [3:0] td [3] = '{4'b1011, 4'b1011, 4'b1011};
      logic [1:0] ts [3] = '{2'd1, 2'd3, 2'd2};
      logic [3:0] te [3] = '{4'b0110, 4'b1000, 4'b1100};
      for (int i = 0; i < 3; i++) begin
         run_op(td[i], ts[i], 1'b0, res, lat);
         n_checks++;
         if (res !== te[i]) begin
            n_fail++;
            $display("FAIL logical_result[%0d]: y=%b, required %b", i, res, te[i]);
         end
         n_checks++;
         if (lat !== int'(ts[i]) + 1) begin
            n_fail++;
            $display("FAIL logical_latency[%0d]: %0d cycles, required %0d", i, lat, int'(ts[i]) + 1);
         end
         tick();
         n_checks++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL logical_return_idle[%0d]: in_ready=%b out_valid=%b, required 1 0", i, in_ready, out_valid);
         end
      end
   endtask

   task automatic test_rotate();
      logic [3:0] res;
      int lat;
      logic [3:0] td [3] = '{4'b1011, 4'b1000, 4'b0110};
      logic [1:0] ts [3] = '{2'd3, 2'd1, 2'd2};
      logic [3:0] te [3] = '{4'b1101, 4'b0001, 4'b1001};
      for (int i = 0; i < 3; i++) begin
         run_op(td[i], ts[i], 1'b1, res, lat);
         n_checks++;
         if (res !== te[i]) begin
            n_fail++;
            $display("FAIL rotate_result[%0d]: y=%b, required %b", i, res, te[i]);
         end
         tick();
      end
   endtask

   task automatic test_zero_shift();
      logic [3:0] res;
      int lat;
      run_op(4'b1011, 2'd0, 1'b0, res, lat);
      n_checks++;
      if (res !== 4'b1011 || lat !== 1) begin
         n_fail++;
         $display("FAIL zero_shift: y=%b latency=%0d, required y=1011 latency=1", res, lat);
      end
      tick();
   endtask

   task automatic test_backpressure();
      logic [3:0] res;
      int lat;
      out_ready = 1'b0;
      run_op(4'b0011, 2'd1, 1'b0, res, lat);
      n_checks++;
      if (res !== 4'b0110) begin
         n_fail++;
         $display("FAIL backpressure_result: y=%b, required 0110", res);
      end
      for (int i = 0; i < 5; i++) begin
         in_valid = (i == 2);
         d        = 4'b1111;
         s        = 2'd0;
         tick();
         n_checks++;
         if (y !== 4'b0110 || out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_hold[%0d]: y=%b out_valid=%b busy=%b in_ready=%b, required 0110 1 1 0",
                     i, y, out_valid, busy, in_ready);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || y !== 4'b0110) begin
         n_fail++;
         $display("FAIL backpressure_release: in_ready=%b out_valid=%b y=%b, required 1 0 0110",
                  in_ready, out_valid, y);
      end
   endtask

   task automatic test_reset_mid();
      logic [3:0] res;
      int lat;
      d        = 4'b1011;
      s        = 2'd3;
      rot      = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      n_checks++;
      if (y !== 4'b0110 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_shift_state: y=%b busy=%b, required 0110 1", y, busy);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (y !== 4'b0000 || out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_op: y=%b out_valid=%b in_ready=%b busy=%b, required 0000 0 1 0",
                  y, out_valid, in_ready, busy);
      end
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      run_op(4'b0110, 2'd2, 1'b1, res, lat);
      n_checks++;
      if (res !== 4'b1001 || lat !== 3) begin
         n_fail++;
         $display("FAIL after_reset_op: y=%b latency=%0d, required 1001 3", res, lat);
      end
      tick();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_logical();
      test_rotate();
      test_zero_shift();
      test_backpressure();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
